aes256_key_expansion_seq: RTL and testbench

Iterative AES-256 key schedule that sits directly upstream of the round_block pipeline. It accepts a 256-bit cipher key and computes the 60 expanded words, one word per clock, using 4 shared combinational S-box LUTs. It then presents all 15 round keys as a flattened bus; round r of the cipher pipeline taps slice r.

---
 rtl/aes256_key_expansion_seq.sv | 154 +++++++++++++++
 tb/tb_aes256_key_expansion_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_expansion_seq.sv
// Iterative AES-256 key schedule: one expanded word per clock from a 60-word bank,
// with all 15 round keys exposed on a flat bus for the round pipeline.
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | no valid keys held
// EXPAND | expansion running, one word per clock
// DONE   | all 60 words valid and held

module aes256_key_expansion_seq #(
    parameter int NB_BYTE  = 8,
    parameter int N_BYTES  = 16,
    parameter int N_ROUNDS = 14,
    parameter int NB_KEY   = 256
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset,
    input  logic [NB_KEY-1:0]                      i_key,
    input  logic                                   i_key_valid,
    output logic [(N_ROUNDS+1)*N_BYTES*NB_BYTE-1:0] o_round_keys,
    output logic                                   o_keys_ready,
    output logic                                   o_busy
);

    localparam bit BAD_CONF = (NB_BYTE != 8) || (N_BYTES != 16) ||
                              (N_ROUNDS != 14) || (NB_KEY != 256);
    localparam int NB_WORD  = 4 * NB_BYTE;
    localparam int N_KEYW   = NB_KEY / NB_WORD;
    localparam int N_WORDS  = (N_ROUNDS + 1) * N_BYTES / 4;

    generate
        if (BAD_CONF) begin : g_bad_conf
            $error("aes256_key_expansion_seq: only NB_BYTE=8, N_BYTES=16, N_ROUNDS=14, NB_KEY=256 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [5:0]        cnt;
    logic [NB_WORD-1:0] w_bank [N_WORDS];

    logic              load_accept;
    logic [5:0]        cnt_m1;
    logic [5:0]        cnt_m8;
    logic [31:0]       w_prev;
    logic [31:0]       w_back;
    logic [31:0]       sub_in;
    logic [31:0]       sub_out;
    logic [7:0]        rcon_byte;
    logic [31:0]       temp;
    logic [31:0]       w_new;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, which also maps 0 to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign load_accept = i_key_valid && (state != ST_EXPAND);

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next   = state;
        o_busy       = 1'b0;
        o_keys_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_accept) state_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                o_busy = 1'b1;
                if (cnt == 6'(N_WORDS - 1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_keys_ready = 1'b1;
                if (load_accept) state_next = ST_EXPAND;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Only w[cnt-1] and w[cnt-8] feed the next word
    assign cnt_m1 = cnt - 6'd1;
    assign cnt_m8 = cnt - 6'd8;
    assign w_prev = w_bank[cnt_m1];
    assign w_back = w_bank[cnt_m8];

    assign sub_in  = (cnt[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                      sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    assign rcon_byte = 8'h01 << (cnt[5:3] - 3'd1);

    always_comb begin
        temp = w_prev;
        case (cnt[2:0])
            3'd0:    temp = sub_out ^ {rcon_byte, 24'h000000};
            3'd4:    temp = sub_out;
            default: temp = w_prev;
        endcase
    end

    assign w_new = w_back ^ temp;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt <= 6'd0;
            for (int i = 0; i < N_WORDS; i++) w_bank[i] <= '0;
        end else if (load_accept) begin
            for (int i = 0; i < N_KEYW; i++) w_bank[i] <= i_key[(N_KEYW-1-i)*NB_WORD +: NB_WORD];
            cnt <= 6'(N_KEYW);
        end else if (state == ST_EXPAND) begin
            w_bank[cnt] <= w_new;
            cnt         <= cnt + 6'd1;
        end
    end

    // Word i lands in slice i/4, with the lowest-numbered word at the slice MSBs
    generate
        for (genvar g = 0; g < N_WORDS; g++) begin : g_pack
            assign o_round_keys[(g/4)*128 + (3-(g%4))*32 +: 32] = w_bank[g];
        end
    endgenerate

endmodule

// File: tb/tb_aes256_key_expansion_seq.sv
// Bench for aes256_key_expansion_seq: known-answer table, multi-cycle corner cases and
// randomized keys checked against a plain FIPS-style key expansion model.

module tb_aes256_key_expansion_seq;

    logic           i_clock = 1'b0;
    logic           i_reset = 1'b1;
    logic [255:0]   i_key = '0;
    logic           i_key_valid = 1'b0;
    logic [1919:0]  o_round_keys;
    logic           o_keys_ready;
    logic           o_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes256_key_expansion_seq dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_key        (i_key),
        .i_key_valid  (i_key_valid),
        .o_round_keys (o_round_keys),
        .o_keys_ready (o_keys_ready),
        .o_busy       (o_busy)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [255:0] key;
        int           slice;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gf_mul_poly(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gf_mul_poly(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_tab[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [1919:0] model_expand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[(7-i)*32 +: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        rk = '0;
        for (int i = 0; i < 60; i++) rk[(i/4)*128 + (3-(i%4))*32 +: 32] = w[i];
        return rk;
    endfunction

    function automatic logic [127:0] slice_of(input logic [1919:0] b, input int r);
        return b[r*128 +: 128];
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1919:0] exp_bus);
        for (int r = 0; r < 15; r++)
            check($sformatf("%s_slice%0d", tag, r), slice_of(o_round_keys, r), slice_of(exp_bus, r));
    endtask

    // Drives a load at a negedge; returns at the negedge just after the load edge
    task automatic load_key(input string tag, input logic [255:0] key);
        i_key       = key;
        i_key_valid = 1'b1;
        @(negedge i_clock);
        i_key_valid = 1'b0;
        check({tag, "_busy_at_load"}, 128'(o_busy), 128'(1'b1));
        check({tag, "_ready_at_load"}, 128'(o_keys_ready), 128'(1'b0));
    endtask

    // Counts edges from the load edge until ready, optionally injecting a load while busy
    task automatic wait_ready(input string tag, input int inject_at, input logic [255:0] inj_key);
        int k;
        bit busy_bad;
        k = 0;
        busy_bad = 1'b0;
        while (!o_keys_ready && k < 200) begin
            if (!o_busy) busy_bad = 1'b1;
            if (k == inject_at) begin
                i_key       = inj_key;
                i_key_valid = 1'b1;
            end else begin
                i_key_valid = 1'b0;
            end
            @(negedge i_clock);
            k++;
        end
        i_key_valid = 1'b0;
        check({tag, "_latency"}, 128'(k), 128'(52));
        check({tag, "_busy_held"}, 128'(busy_bad), 128'(1'b0));
        check({tag, "_busy_off_at_ready"}, 128'(o_busy), 128'(1'b0));
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1919:0] exp_c3;
        logic [1919:0] exp_bus;
        logic [255:0]  key;
        int            inj;
        int            gap;
        bit            idle_bad;

        vecs[0] = '{KEY_C3, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{KEY_C3, 1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2] = '{KEY_C3, 2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3] = '{KEY_C3, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};

        build_sbox();
        exp_c3 = model_expand(KEY_C3);

        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;

        // Reset values held through 100 idle cycles
        idle_bad = 1'b0;
        check("rst_ready", 128'(o_keys_ready), 128'(1'b0));
        check("rst_busy", 128'(o_busy), 128'(1'b0));
        check_all("rst", '0);
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clock);
            if (o_keys_ready || o_busy || (o_round_keys != '0)) idle_bad = 1'b1;
        end
        check("idle_100_stable", 128'(idle_bad), 128'(1'b0));

        // Known-answer table
        load_key("c3", vecs[0].key);
        wait_ready("c3", -1, '0);
        for (int v = 0; v < 4; v++)
            check($sformatf("kat_slice%0d", vecs[v].slice),
                  slice_of(o_round_keys, vecs[v].slice), vecs[v].exp);
        check_all("c3_model", exp_c3);

        // Load while busy is ignored
        repeat (3) @(negedge i_clock);
        check_all("done_stable", exp_c3);
        load_key("busyld", KEY_C3);
        wait_ready("busyld", 19, {256{1'b1}});
        check_all("busyld", exp_c3);

        // Reload from DONE with the zero key
        @(negedge i_clock);
        load_key("zero", '0);
        wait_ready("zero", -1, '0);
        exp_bus = model_expand('0);
        check("zero_slice14", slice_of(o_round_keys, 14), slice_of(exp_bus, 14));
        check_all("zero", exp_bus);

        // Reset mid-expansion, with a load in the reset cycle that must be dropped
        load_key("midrst", KEY_C3);
        repeat (29) @(negedge i_clock);
        i_reset     = 1'b1;
        i_key       = {256{1'b1}};
        i_key_valid = 1'b1;
        @(negedge i_clock);
        i_reset     = 1'b0;
        i_key_valid = 1'b0;
        check("midrst_ready", 128'(o_keys_ready), 128'(1'b0));
        check("midrst_busy", 128'(o_busy), 128'(1'b0));
        check_all("midrst", '0);
        idle_bad = 1'b0;
        repeat (4) begin
            @(negedge i_clock);
            if (o_keys_ready || o_busy || (o_round_keys != '0)) idle_bad = 1'b1;
        end
        check("midrst_idle", 128'(idle_bad), 128'(1'b0));
        load_key("postrst", KEY_C3);
        wait_ready("postrst", -1, '0);
        check_all("postrst", exp_c3);

        // Random regression
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp_bus = model_expand(key);
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 51)) : -1;
            load_key($sformatf("rnd%0d", n), key);
            wait_ready($sformatf("rnd%0d", n), inj,
                       {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            check_all($sformatf("rnd%0d", n), exp_bus);
            gap = $urandom_range(0, 4);
            repeat (gap) @(negedge i_clock);
            if (gap != 0) check_all($sformatf("rnd%0d_hold", n), exp_bus);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
